// File: rtl/seven_segment_mux_if.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_mux_if
// Brief   : Data/display bundle between a host and the seven_segment_mux scanner.
// Revision: 1.0
// ============================================================================
interface seven_segment_mux_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);
    logic [4*DIGITS-1:0]  value;
    logic [DIGITS-1:0]    dp;
    logic                 load;
    logic                 blank_lz;
    logic [BRIGHT_W-1:0]  brightness;
    logic [7:0]           seg;
    logic [DIGITS-1:0]    dig;
    logic                 frame;

    modport master (
        output value, dp, load, blank_lz, brightness,
        input  seg, dig, frame
    );

    modport slave (
        input  value, dp, load, blank_lz, brightness,
        output seg, dig, frame
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_mux.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_mux
// Brief   : Time-multiplexed multi-digit seven-segment driver with tear-free
//           frame update, dead cycle, PWM brightness and zero blanking.
// Revision: 1.0
// ============================================================================
module seven_segment_mux #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1200,
    parameter int BRIGHT_W       = 3,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    seven_segment_mux_if.slave  bus
);

    localparam int c_PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_IDX_W = $clog2(DIGITS);
    localparam int c_ON_W  = c_PRE_W + 1;
    localparam int c_STEP  = CLK_DIV >> BRIGHT_W;

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);
    localparam logic               c_SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic               c_DIG_INV  = (DIG_ACTIVE_LOW != 0);
    localparam logic [7:0]         c_SEG_OFF  = {8{c_SEG_INV}};
    localparam logic [DIGITS-1:0]  c_DIG_OFF  = {DIGITS{c_DIG_INV}};

    logic [c_PRE_W-1:0]    r_pre;
    logic [c_IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0]   r_shadow_val;
    logic [DIGITS-1:0]     r_shadow_dp;
    logic [4*DIGITS-1:0]   r_disp_val;
    logic [DIGITS-1:0]     r_disp_dp;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_dig;
    logic                  r_frame;

    logic                  w_pre_last;
    logic                  w_wrap;
    logic [3:0]            w_cur_nib;
    logic                  w_cur_dp;
    logic                  w_cur_zero;
    logic [DIGITS:0]       w_zero_from;
    logic                  w_blank;
    logic [7:0]            w_seg;
    logic [c_ON_W-1:0]     w_on_time;
    logic                  w_en;
    logic [DIGITS-1:0]     w_dig_hot;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] abcdefg;
        case (nib)
            4'h0:    abcdefg = 7'b1111110;
            4'h1:    abcdefg = 7'b0110000;
            4'h2:    abcdefg = 7'b1101101;
            4'h3:    abcdefg = 7'b1111001;
            4'h4:    abcdefg = 7'b0110011;
            4'h5:    abcdefg = 7'b1011011;
            4'h6:    abcdefg = 7'b1011111;
            4'h7:    abcdefg = 7'b1110000;
            4'h8:    abcdefg = 7'b1111111;
            4'h9:    abcdefg = 7'b1111011;
            4'hA:    abcdefg = 7'b1110111;
            4'hB:    abcdefg = 7'b0011111;
            4'hC:    abcdefg = 7'b1001110;
            4'hD:    abcdefg = 7'b0111101;
            4'hE:    abcdefg = 7'b1001111;
            default: abcdefg = 7'b1000111;
        endcase
        return abcdefg;
    endfunction

    assign w_pre_last = (r_pre == c_PRE_LAST);
    assign w_wrap     = w_pre_last && (r_idx == c_IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_pre_last) begin
            r_pre <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // Display only changes at the wrap, and takes the shadow as it stood before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
        end else begin
            if (bus.load) begin
                r_shadow_val <= bus.value;
                r_shadow_dp  <= bus.dp;
            end
            if (w_wrap) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
            end
        end
    end

    // w_zero_from[i] is set when nibble i and every more significant nibble is zero.
    always_comb begin
        w_cur_nib           = 4'h0;
        w_cur_dp            = 1'b0;
        w_cur_zero          = 1'b0;
        w_zero_from         = '0;
        w_zero_from[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_from[i] = (r_disp_val[4*i +: 4] == 4'h0) && w_zero_from[i+1];
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_cur_nib  = r_disp_val[4*i +: 4];
                w_cur_dp   = r_disp_dp[i];
                w_cur_zero = w_zero_from[i];
            end
        end
    end

    assign w_blank = bus.blank_lz && (r_idx != '0) && w_cur_zero;
    assign w_seg   = {(w_blank ? 7'b0000000 : f_decode(w_cur_nib)), w_cur_dp};

    // pre == 0 is always dark so the previous digit's drivers settle before the next lights.
    assign w_on_time = (c_ON_W'(bus.brightness) + c_ON_W'(1)) * c_ON_W'(c_STEP);
    assign w_en      = (r_pre != '0) && ({1'b0, r_pre} < w_on_time);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_dig
            assign w_dig_hot[i] = w_en && (r_idx == c_IDX_W'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg   <= c_SEG_OFF;
            r_dig   <= c_DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg ^ {8{c_SEG_INV}};
            r_dig   <= w_dig_hot ^ {DIGITS{c_DIG_INV}};
            r_frame <= w_wrap;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.dig   = r_dig;
    assign bus.frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_mux
// Brief   : Scoreboard bench for seven_segment_mux (4 digits, 16-cycle slots).
// Revision: 1.0
// ============================================================================
module tb_seven_segment_mux;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       frame;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];

    // Observation summary of the most recent run_frame call
    int         f_lit [4];
    logic [7:0] f_seg [4];
    int         f_pos [4];
    bit         f_var;
    int         f_fpos;
    int         f_npulse;
    int         f_mism;
    int         f_first_d;
    out_t       f_e1, f_o1, f_last;

    seven_segment_mux_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

    seven_segment_mux #(
        .DIGITS(4), .CLK_DIV(16), .BRIGHT_W(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one expected output word per clock edge.
    initial begin : model
        logic [6:0]  tbl [16];
        logic [15:0] m_shv, m_dv;
        logic [3:0]  m_shdp, m_ddp;
        logic [3:0]  nib;
        logic [6:0]  s;
        int          m_pre, m_idx, on;
        out_t        me;
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        m_shv = '0; m_dv = '0; m_shdp = '0; m_ddp = '0; m_pre = 0; m_idx = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                me.seg = 8'h00; me.dig = 4'hF; me.frame = 1'b0;
                m_pre = 0; m_idx = 0;
                m_shv = '0; m_dv = '0; m_shdp = '0; m_ddp = '0;
            end else begin
                nib = 4'(m_dv >> (4 * m_idx));
                s   = tbl[nib];
                if (bus.blank_lz && m_idx != 0 && (m_dv >> (4 * m_idx)) == 16'h0) s = 7'h00;
                me.seg   = {s, m_ddp[m_idx]};
                on       = (int'(bus.brightness) + 1) * 4;
                me.dig   = (m_pre >= 1 && m_pre < on) ? ~(4'b0001 << m_idx) : 4'b1111;
                me.frame = (m_idx == 3 && m_pre == 15);
                if (me.frame) begin m_dv = m_shv; m_ddp = m_shdp; end
                if (bus.load) begin m_shv = bus.value; m_shdp = bus.dp; end
                m_pre++;
                if (m_pre == 16) begin m_pre = 0; m_idx = (m_idx + 1) % 4; end
            end
            exp_q.push_back(me);
        end
    end

    task automatic tick(output out_t e, output out_t o);
        @(negedge clk);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
        o.seg = bus.seg; o.dig = bus.dig; o.frame = bus.frame;
    endtask

    task automatic wait_frame(output bit ok);
        out_t e, o;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick(e, o);
            if (o.frame === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_frame(input int n);
        out_t e, o;
        f_mism = 0; f_fpos = 0; f_npulse = 0; f_var = 0; f_first_d = -1;
        for (int d = 0; d < 4; d++) begin f_lit[d] = 0; f_seg[d] = '0; f_pos[d] = -1; end
        for (int j = 1; j <= n; j++) begin
            tick(e, o);
            if (o !== e) begin
                if (f_mism == 0) begin f_e1 = e; f_o1 = o; end
                f_mism++;
            end
            if (o.frame === 1'b1) begin
                f_npulse++;
                if (f_fpos == 0) f_fpos = j;
            end
            for (int d = 0; d < 4; d++) begin
                if (o.dig === ~(4'b0001 << d)) begin
                    if (f_lit[d] == 0) begin f_seg[d] = o.seg; f_pos[d] = (j - 1) % 16; end
                    else if (o.seg !== f_seg[d]) f_var = 1'b1;
                    if (f_first_d < 0) f_first_d = d;
                    f_lit[d]++;
                end
            end
            f_last = o;
        end
    endtask

    task automatic test_reset();
        out_t e, o;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(e, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_model: got %h, expected %h", o, e);
            end
            checks++;
            if (o.seg !== 8'h00 || o.dig !== 4'hF || o.frame !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: got seg=%h dig=%b frame=%b, expected seg=00 dig=1111 frame=0",
                         o.seg, o.dig, o.frame);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_digits();
        bit ok;
        logic [7:0] want [4];
        want = '{8'h66, 8'hF2, 8'hDA, 8'h60};
        bus.value = 16'h1234; bus.dp = 4'b0000; bus.brightness = 2'd3; bus.load = 1'b1;
        run_frame(1);
        bus.load = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL digits_wait: no frame pulse within 200 cycles"); end
        run_frame(64);
        checks++;
        if (f_mism != 0) begin
            errors++;
            $display("FAIL digits_model: %0d mismatches, first got %h expected %h", f_mism, f_o1, f_e1);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (f_seg[d] !== want[d] || f_lit[d] != 15) begin
                errors++;
                $display("FAIL digits_slot%0d: got seg=%h lit=%0d, expected seg=%h lit=15",
                         d, f_seg[d], f_lit[d], want[d]);
            end
        end
        checks++;
        if (f_fpos != 64 || f_npulse != 1) begin
            errors++;
            $display("FAIL digits_frame: got pulse at %0d (count %0d), expected at 64 (count 1)", f_fpos, f_npulse);
        end
    endtask

    task automatic test_brightness();
        bit ok;
        int want_lit [2];
        want_lit = '{3, 7};
        for (int b = 0; b < 2; b++) begin
            bus.brightness = 2'(b);
            wait_frame(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL bright_wait: no frame pulse within 200 cycles"); end
            run_frame(64);
            checks++;
            if (f_mism != 0) begin
                errors++;
                $display("FAIL bright_model: %0d mismatches, first got %h expected %h", f_mism, f_o1, f_e1);
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (f_lit[d] != want_lit[b] || f_pos[d] != 1) begin
                    errors++;
                    $display("FAIL bright%0d_slot%0d: got lit=%0d first=%0d, expected lit=%0d first=1",
                             b, d, f_lit[d], f_pos[d], want_lit[b]);
                end
            end
        end
        bus.brightness = 2'd3;
    endtask

    task automatic test_blanking();
        bit ok;
        logic [7:0] want [2][4];
        want = '{'{8'hE0, 8'h00, 8'h01, 8'h00}, '{8'hE0, 8'hFC, 8'hFD, 8'hFC}};
        bus.value = 16'h0007; bus.dp = 4'b0100; bus.blank_lz = 1'b1; bus.load = 1'b1;
        run_frame(1);
        bus.load = 1'b0;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blank_wait: no frame pulse within 200 cycles"); end
        for (int p = 0; p < 2; p++) begin
            run_frame(64);
            checks++;
            if (f_mism != 0 || f_fpos != 64) begin
                errors++;
                $display("FAIL blank%0d_model: %0d mismatches pulse at %0d, expected 0 and 64", p, f_mism, f_fpos);
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (f_seg[d] !== want[p][d]) begin
                    errors++;
                    $display("FAIL blank%0d_digit%0d: got seg=%h, expected %h", p, d, f_seg[d], want[p][d]);
                end
            end
            bus.blank_lz = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] want [2];
        want = '{8'hEE, 8'hB6};
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL tear_wait: no frame pulse within 200 cycles"); end
        run_frame(20);
        bus.value = 16'hAAAA; bus.dp = 4'b0000; bus.load = 1'b1;
        run_frame(1);
        bus.load = 1'b0;
        run_frame(42);
        bus.value = 16'h5555; bus.load = 1'b1;
        run_frame(1);
        bus.load = 1'b0;
        checks++;
        if (f_fpos != 1) begin
            errors++;
            $display("FAIL tear_wrap_load: load tick frame pulse at %0d, expected 1", f_fpos);
        end
        for (int p = 0; p < 2; p++) begin
            run_frame(64);
            checks++;
            if (f_mism != 0 || f_var || f_fpos != 64) begin
                errors++;
                $display("FAIL tear%0d_frame: mismatches=%0d mixed=%0d pulse=%0d, expected 0 0 64",
                         p, f_mism, f_var, f_fpos);
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (f_seg[d] !== want[p]) begin
                    errors++;
                    $display("FAIL tear%0d_digit%0d: got seg=%h, expected %h", p, d, f_seg[d], want[p]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_frame(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_wait: no frame pulse within 200 cycles"); end
        run_frame(40);
        rst = 1'b1;
        run_frame(1);
        rst = 1'b0;
        checks++;
        if (f_last.dig !== 4'hF || f_last.seg !== 8'h00 || f_last.frame !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out: got seg=%h dig=%b frame=%b, expected 00 1111 0",
                     f_last.seg, f_last.dig, f_last.frame);
        end
        run_frame(64);
        checks++;
        if (f_mism != 0 || f_fpos != 64 || f_first_d != 0) begin
            errors++;
            $display("FAIL rstmid_scan: mismatches=%0d pulse=%0d first_digit=%0d, expected 0 64 0",
                     f_mism, f_fpos, f_first_d);
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (f_seg[d] !== 8'hFC || f_lit[d] != 15) begin
                errors++;
                $display("FAIL rstmid_digit%0d: got seg=%h lit=%0d, expected FC 15", d, f_seg[d], f_lit[d]);
            end
        end
    endtask

    task automatic test_random();
        out_t e, o;
        int prev_d, cur_d, pulses;
        prev_d = -1; pulses = 0;
        for (int j = 0; j < 640; j++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.value = 16'($urandom); bus.dp = 4'($urandom); bus.load = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) bus.brightness = 2'($urandom);
            if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
            tick(e, o);
            bus.load = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand_model: cycle %0d got %h, expected %h", j, o, e);
            end
            checks++;
            if ($countones(~o.dig) > 1) begin
                errors++;
                $display("FAIL rand_onehot: cycle %0d got dig=%b, expected at most one low", j, o.dig);
            end
            cur_d = -1;
            for (int d = 0; d < 4; d++) if (o.dig === ~(4'b0001 << d)) cur_d = d;
            checks++;
            if (cur_d >= 0 && prev_d >= 0 && cur_d != prev_d) begin
                errors++;
                $display("FAIL rand_dead: cycle %0d digit %0d follows digit %0d with no dark cycle", j, cur_d, prev_d);
            end
            prev_d = cur_d;
            if (o.frame === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL rand_frames: got %0d pulses, expected 10", pulses);
        end
    endtask

    initial begin
        bus.value = '0; bus.dp = '0; bus.load = 1'b0; bus.blank_lz = 1'b0; bus.brightness = 2'd3;
        test_reset();
        test_digits();
        test_brightness();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
